// File: rtl/gnn_0_example_save_buffer_pkg.sv
// Shared constants and FSM state type for the save buffer.
package gnn_0_example_save_buffer_pkg;

  localparam int unsigned DATA_WIDTH   = 512;
  localparam int unsigned ADDR_WIDTH   = 11;
  localparam int unsigned DEPTH        = 1 << ADDR_WIDTH;
  localparam int unsigned READ_LATENCY = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/gnn_0_example_save_buffer_ram.sv
// Byte-enable line store with a registered, read-first read port. No reset on the array.
module gnn_0_example_save_buffer_ram #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  input  logic                  re_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned i = 0; i < DATA_W/8; i++) begin
        if (wstrb_i[i]) mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gnn_0_example_save_buffer.sv
// Save buffer top: clear FSM, write mux, 3-cycle read pipeline.
// Optional macro SAVE_BUF_WR_FWD_EN selects write-first collision behaviour (default read-first).
module gnn_0_example_save_buffer
  import gnn_0_example_save_buffer_pkg::*;
#(
  parameter int unsigned C_M_AXI_DATA_WIDTH = DATA_WIDTH,
  parameter int unsigned BUF_ADDR_WIDTH     = ADDR_WIDTH
) (
  input  logic                            aclk,
  input  logic                            areset,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [BUF_ADDR_WIDTH-1:0]       wr_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   wr_data,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] wr_strb,
  input  logic                            save_read_buffer_addr_valid,
  input  logic [BUF_ADDR_WIDTH-1:0]       save_read_buffer_addr,
  output logic                            save_read_buffer_data_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   save_read_buffer_data,
  input  logic                            clear_start,
  output logic                            clear_busy
);

  localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;
  localparam logic [BUF_ADDR_WIDTH-1:0] LAST_LINE = '1;

  state_e                        state_q;
  logic [BUF_ADDR_WIDTH-1:0]     clr_cnt_q;
  logic                          ram_we;
  logic [BUF_ADDR_WIDTH-1:0]     ram_waddr;
  logic [C_M_AXI_DATA_WIDTH-1:0] ram_wdata;
  logic [STRB_W-1:0]             ram_wstrb;
  logic [C_M_AXI_DATA_WIDTH-1:0] ram_rdata;
  logic [C_M_AXI_DATA_WIDTH-1:0] merged_d;
  logic [C_M_AXI_DATA_WIDTH-1:0] s2_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] data_q;
  logic [READ_LATENCY-1:0]       vld_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_start) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
          end
        end
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_LINE) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign clear_busy = (state_q == ST_CLEAR);
  assign wr_ready   = (state_q == ST_IDLE) && !clear_start && !areset;

  // Clear owns the write port; reset suppresses the in-progress clear write.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    ram_wstrb = wr_strb;
    if (state_q == ST_CLEAR && !areset) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt_q;
      ram_wdata = '0;
      ram_wstrb = '1;
    end else if (wr_valid && wr_ready) begin
      ram_we = 1'b1;
    end
  end

  gnn_0_example_save_buffer_ram #(
    .DATA_W (C_M_AXI_DATA_WIDTH),
    .ADDR_W (BUF_ADDR_WIDTH)
  ) u_ram (
    .clk_i   (aclk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .wstrb_i (ram_wstrb),
    .re_i    (save_read_buffer_addr_valid),
    .raddr_i (save_read_buffer_addr),
    .rdata_o (ram_rdata)
  );

`ifdef SAVE_BUF_WR_FWD_EN
  logic                          fwd_hit_q;
  logic [C_M_AXI_DATA_WIDTH-1:0] fwd_data_q;
  logic [STRB_W-1:0]             fwd_strb_q;

  // Capture the colliding write alongside the RAM read so stage 2 can overlay it.
  always_ff @(posedge aclk) begin
    fwd_hit_q  <= ram_we && save_read_buffer_addr_valid && (ram_waddr == save_read_buffer_addr);
    fwd_data_q <= ram_wdata;
    fwd_strb_q <= ram_wstrb;
  end

  always_comb begin
    merged_d = ram_rdata;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (fwd_hit_q && fwd_strb_q[i]) merged_d[8*i +: 8] = fwd_data_q[8*i +: 8];
    end
  end
`else
  always_comb begin
    merged_d = ram_rdata;
  end
`endif

  // Stages: RAM register, merge register, output register (vld_q[0..2]).
  always_ff @(posedge aclk) begin
    if (areset) begin
      vld_q  <= '0;
      s2_q   <= '0;
      data_q <= '0;
    end else begin
      vld_q <= {vld_q[READ_LATENCY-2:0], save_read_buffer_addr_valid};
      if (vld_q[0]) s2_q   <= merged_d;
      if (vld_q[1]) data_q <= s2_q;
    end
  end

  assign save_read_buffer_data_valid = vld_q[READ_LATENCY-1];
  assign save_read_buffer_data       = data_q;

endmodule

// File: tb/tb_gnn_0_example_save_buffer.sv
// Randomized + directed bench for gnn_0_example_save_buffer against a line-array reference model.
module tb_gnn_0_example_save_buffer;
  import gnn_0_example_save_buffer_pkg::*;

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int SW = DW / 8;

  logic          aclk = 1'b0;
  logic          areset;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rd_dvalid;
  logic [DW-1:0] rd_data;
  logic          clear_start;
  logic          clear_busy;

  gnn_0_example_save_buffer #(
    .C_M_AXI_DATA_WIDTH (DW),
    .BUF_ADDR_WIDTH     (AW)
  ) dut (
    .aclk                        (aclk),
    .areset                      (areset),
    .wr_valid                    (wr_valid),
    .wr_ready                    (wr_ready),
    .wr_addr                     (wr_addr),
    .wr_data                     (wr_data),
    .wr_strb                     (wr_strb),
    .save_read_buffer_addr_valid (rd_valid),
    .save_read_buffer_addr       (rd_addr),
    .save_read_buffer_data_valid (rd_dvalid),
    .save_read_buffer_data       (rd_data),
    .clear_start                 (clear_start),
    .clear_busy                  (clear_busy)
  );

  always #5 aclk = ~aclk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: line array, pending-response queue, clear progress.
  typedef struct {
    longint        due;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] mdl_mem [DEPTH];
  rsp_t          rsp_q[$];
  bit            mdl_busy = 0;
  int            mdl_idx  = 0;
  logic [DW-1:0] mdl_last = '0;
  longint        cyc      = 0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] strb);
    logic [DW-1:0] r = old;
    for (int i = 0; i < SW; i++) if (strb[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [SW-1:0] rand_strb();
    logic [SW-1:0] v;
    for (int i = 0; i < SW/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Checks this cycle's outputs, then advances the model over the closing edge.
  task automatic cycle();
    logic          exp_ready, exp_v, we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd, rd;
    logic [SW-1:0] ws;
    @(negedge aclk);
    exp_ready = !mdl_busy && !clear_start && !areset;
    check_val("wr_ready", DW'(wr_ready), DW'(exp_ready));
    check_val("clear_busy", DW'(clear_busy), DW'(mdl_busy));
    exp_v = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      exp_v    = 1'b1;
      mdl_last = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    check_val("data_valid", DW'(rd_dvalid), DW'(exp_v));
    check_val("data", rd_data, mdl_last);
    if (areset) begin
      rsp_q.delete();
      mdl_last = '0;
      mdl_busy = 0;
    end else begin
      we = 1'b0; wa = wr_addr; wd = wr_data; ws = wr_strb;
      if (mdl_busy) begin
        we = 1'b1; wa = AW'(mdl_idx); wd = '0; ws = '1;
      end else if (wr_valid && exp_ready) begin
        we = 1'b1;
      end
      if (rd_valid) begin
        rd = mdl_mem[rd_addr];
`ifdef SAVE_BUF_WR_FWD_EN
        if (we && wa == rd_addr) rd = merge(rd, wd, ws);
`endif
        rsp_q.push_back('{cyc + READ_LATENCY, rd});
      end
      if (we) mdl_mem[wa] = merge(mdl_mem[wa], wd, ws);
      if (mdl_busy) begin
        mdl_idx++;
        if (mdl_idx == DEPTH) mdl_busy = 0;
      end else if (clear_start) begin
        mdl_busy = 1;
        mdl_idx  = 0;
      end
    end
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    wr_valid = 0; rd_valid = 0; clear_start = 0;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    idle(); wr_valid = 1; wr_addr = AW'(a); wr_data = d; wr_strb = s;
    cycle();
  endtask

  task automatic do_read(input int a);
    idle(); rd_valid = 1; rd_addr = AW'(a);
    cycle();
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    areset = 1; wr_addr = '0; wr_data = '0; wr_strb = '0; rd_addr = '0;
    idle();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    repeat (2) @(posedge aclk);
    #1;
    idle_cycles(3);
    areset = 0;

    // Initial clear, with a redundant clear_start in the middle.
    clear_start = 1; cycle(); idle();
    for (int i = 0; i < DEPTH + 4; i++) begin
      clear_start = (i == 500);
      cycle();
    end
    idle();
    do_read(DEPTH - 1);
    idle_cycles(4);
    check_val("clear_last_line", rd_data, '0);

    do_write(5, {SW{8'hA5}}, '1);
    do_read(5);
    idle_cycles(4);
    check_val("a5_pattern", rd_data, {SW{8'hA5}});

    do_write(7, {SW{8'hFF}}, '1);
    do_write(7, '0, SW'(1));
    do_read(7);
    idle_cycles(4);
    check_val("byte0_strobe", rd_data, {{(SW-1){8'hFF}}, 8'h00});

    for (int a = 0; a < 4; a++) do_read(a);
    idle_cycles(4);

    do_write(9, {SW{8'h22}}, '1);
    idle();
    wr_valid = 1; wr_addr = 9; wr_data = {SW{8'h11}}; wr_strb = '1;
    rd_valid = 1; rd_addr = 9;
    cycle();
    idle_cycles(4);
`ifdef SAVE_BUF_WR_FWD_EN
    check_val("collision", rd_data, {SW{8'h11}});
`else
    check_val("collision", rd_data, {SW{8'h22}});
`endif

    // Random traffic concentrated on a few lines to provoke collisions.
    for (int i = 0; i < 3000; i++) begin
      wr_valid    = $urandom_range(0, 1);
      wr_addr     = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      wr_data     = rand_line();
      wr_strb     = rand_strb();
      rd_valid    = $urandom_range(0, 1);
      rd_addr     = AW'($urandom_range(0, 15));
      clear_start = ($urandom_range(0, 1499) == 0);
      cycle();
    end
    idle();
    for (int i = 0; i < DEPTH + 2 && mdl_busy; i++) cycle();
    check_val("clear_done", DW'(mdl_busy), '0);

    // Reset at clear cycle 100 with reads in flight.
    do_write(200, rand_line(), '1);
    do_write(150, rand_line(), '1);
    do_write(50, rand_line(), '1);
    idle(); clear_start = 1; cycle(); idle();
    for (int i = 0; i < 98; i++) cycle();
    do_read(300);
    do_read(301);
    idle(); areset = 1; cycle();
    areset = 0;
    idle_cycles(3);
    for (int a = 0; a < 100; a++) do_read(a);
    do_read(150);
    do_read(200);
    idle_cycles(4);
    check_val("rsp_drained", DW'(rsp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gnn_0_example_save_buffer.md
GNN_0_EXAMPLE_SAVE_BUFFER -- requirements
Module: gnn_0_example_save_buffer

Interface
REQ-001 Parameter C_M_AXI_DATA_WIDTH, default 512, SHALL set the buffer line width in bits.
REQ-002 Parameter BUF_ADDR_WIDTH, default 11, SHALL set depth to 2**BUF_ADDR_WIDTH lines (2048).
REQ-003 Port aclk  input  1  SHALL be the single clock; all logic is rising-edge aclk.
REQ-004 Port areset  input  1  SHALL be the reset, synchronous and active-high.
REQ-005 Port wr_valid  input  1  SHALL mark a write request from the compute stage.
REQ-006 Port wr_ready  output  1  SHALL mark write acceptance.
REQ-007 Port wr_addr  input  BUF_ADDR_WIDTH  SHALL carry the write line address.
REQ-008 Port wr_data  input  C_M_AXI_DATA_WIDTH  SHALL carry the write data.
REQ-009 Port wr_strb  input  C_M_AXI_DATA_WIDTH/8  SHALL carry byte enables.
REQ-010 Port save_read_buffer_addr_valid  input  1  SHALL mark a read request from the save stage.
REQ-011 Port save_read_buffer_addr  input  BUF_ADDR_WIDTH  SHALL carry the read line address.
REQ-012 Port save_read_buffer_data_valid  output  1  SHALL mark returned read data.
REQ-013 Port save_read_buffer_data  output  C_M_AXI_DATA_WIDTH  SHALL carry returned read data.
REQ-014 Port clear_start  input  1  SHALL request zeroing of the whole buffer.
REQ-015 Port clear_busy  output  1  SHALL be high while clearing.

Function
REQ-016 A write SHALL commit when wr_valid && wr_ready; only bytes with wr_strb[i]=1 change.
REQ-017 The FSM SHALL have two states: IDLE and CLEAR.
REQ-018 wr_ready SHALL be 1 only in IDLE with clear_start=0 and areset=0; it SHALL be combinational from state and clear_start.
REQ-019 IDLE -> CLEAR SHALL occur on clear_start=1; clear_start in CLEAR SHALL be ignored.
REQ-020 CLEAR SHALL write all-zero data to one line per cycle, addresses 0..2047 ascending, with clear_busy=1.
REQ-021 CLEAR -> IDLE SHALL occur in the cycle after line 2047 is written; the clear takes exactly 2048 cycles.
REQ-022 Reads SHALL never be back-pressured; every cycle with addr_valid=1 SHALL be accepted, in IDLE and in CLEAR.
REQ-023 A read accepted in cycle N SHALL produce data_valid=1 with its data in cycle N+3 exactly, in request order.
REQ-024 Back-to-back reads SHALL give back-to-back data_valid pulses with no gaps.
REQ-025 When data_valid=0, save_read_buffer_data SHALL hold its previous value.
REQ-026 A read and a write (compute or clear) to different addresses in the same cycle SHALL both complete.

Reset
REQ-027 Under areset: data_valid=0, data=0, clear_busy=0, wr_ready=0, state=IDLE, clear counter=0, read-pipeline valid bits=0.
REQ-028 Reset mid-clear SHALL abort the clear; lines already zeroed stay zeroed and the rest keep their prior contents.
REQ-029 Reads in flight at reset SHALL be dropped with no data_valid pulse.
REQ-030 Reset SHALL NOT initialise the storage array.

Configuration
REQ-031 With macro SAVE_BUF_WR_FWD_EN defined, a same-cycle read and write to the same address SHALL return the newly written bytes merged per wr_strb (write-first), including clear writes.
REQ-032 Without SAVE_BUF_WR_FWD_EN, the same collision SHALL return the pre-write contents (read-first).

Structure
REQ-033 Package gnn_0_example_save_buffer_pkg SHALL hold the width, depth and READ_LATENCY=3 constants and the FSM state enum.
REQ-034 Sub-module gnn_0_example_save_buffer_ram SHALL implement the byte-enable array with a registered read; the top module holds the FSM, clear counter, forwarding and the output pipeline.

Verification
REQ-035 Write 0xA5 pattern to addr 5 (strb all ones), then read addr 5 -> data_valid exactly 3 cycles after the request, data=0xA5 pattern.
REQ-036 Write addr 7 = all 0xFF, then write addr 7 = 0x00 with strb=0x1 -> a read of addr 7 returns byte0=0x00 and bytes 1..63=0xFF.
REQ-037 Issue reads of addrs 0,1,2,3 on consecutive cycles -> four consecutive data_valid pulses, in order, starting 3 cycles after the first request.
REQ-038 Pulse clear_start -> clear_busy high for 2048 cycles and wr_ready low throughout; afterwards a read of addr 2047 returns 0 and a second clear_start during the clear has no effect.
REQ-039 Same-cycle write of 0x11 pattern and read of addr 9 (old value 0x22) -> data 0x11 with SAVE_BUF_WR_FWD_EN, 0x22 without.
REQ-040 Assert areset at clear cycle 100 with two reads in flight -> no data_valid pulse; clear_busy=0 next cycle; lines 0..99 read as 0, line 200 keeps its old value.
